// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the lifo_stack block.
package lifo_stack_pkg;

    // Encoding follows {push, pop}.
    typedef enum logic [1:0] {
        NOP     = 2'b00,
        POP     = 2'b01,
        PUSH    = 2'b10,
        REPLACE = 2'b11
    } op_e;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module lifo_stack_mem
    import lifo_stack_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with push/pop/replace, saturating count and status flags.
// Define LIFO_STACK_ERR_EN to enable registered overflow/underflow pulses.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = depth_of(ADDR_W) - 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] top_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned   DEPTH  = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C   = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

    op_e               op;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W:0]   top_pos;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] r_data;
    logic              we;
    logic              is_full;
    logic              is_empty;

    assign op       = op_e'({push, pop});
    assign is_full  = (count_reg == FULL_C);
    assign is_empty = (count_reg == '0);
    assign top_pos  = count_reg - ONE;

    // Replace on an empty stack degenerates to a push at address 0.
    always_comb begin
        we         = 1'b0;
        w_addr     = count_reg[ADDR_W-1:0];
        count_next = count_reg;
        case (op)
            PUSH: begin
                if (!is_full) begin
                    we         = 1'b1;
                    count_next = count_reg + ONE;
                end
            end
            POP: begin
                if (!is_empty) begin
                    count_next = top_pos;
                end
            end
            REPLACE: begin
                we = 1'b1;
                if (is_empty) begin
                    count_next = ONE;
                end else begin
                    w_addr = top_pos[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    lifo_stack_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (we && reset_n),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_addr (top_pos[ADDR_W-1:0]),
        .r_data (r_data)
    );

    assign top_data    = is_empty ? '0 : r_data;
    assign count       = count_reg;
    assign full        = is_full;
    assign empty       = is_empty;
    assign almost_full = (count_reg >= AF_C);

`ifdef LIFO_STACK_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (op == PUSH) && is_full;
            underflow <= (op == POP) && is_empty;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (DATA_W=8, ADDR_W=2, AF_LEVEL=3).
module tb_lifo_stack;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned AF = 3;
`ifdef LIFO_STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          push;
    logic          pop;
    logic [DW-1:0] w_data;
    logic [DW-1:0] top_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    lifo_stack #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .AF_LEVEL (AF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (push),
        .pop         (pop),
        .w_data      (w_data),
        .top_data    (top_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    typedef struct {
        logic [AW:0]   cnt;
        logic [DW-1:0] top;
        logic          full;
        logic          empty;
        logic          af;
        logic          ovf;
        logic          unf;
    } exp_t;

    typedef struct {
        logic          rst_n;
        logic          push;
        logic          pop;
        logic [DW-1:0] wd;
        exp_t          e;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [DW-1:0] mdl [4];
    int unsigned   mcnt;

    function automatic exp_t mk(input int unsigned cnt, input logic [DW-1:0] top,
                                input logic ovf, input logic unf);
        exp_t e;
        e.cnt   = (AW+1)'(cnt);
        e.top   = top;
        e.full  = (cnt == 4);
        e.empty = (cnt == 0);
        e.af    = (cnt >= AF);
        e.ovf   = ovf & ERR;
        e.unf   = unf & ERR;
        return e;
    endfunction

    function automatic vec_t v(input logic r, input logic pu, input logic po,
                               input logic [DW-1:0] wd, input int unsigned cnt,
                               input logic [DW-1:0] top, input logic ovf, input logic unf);
        vec_t t;
        t.rst_n = r;
        t.push  = pu;
        t.pop   = po;
        t.wd    = wd;
        t.e     = mk(cnt, top, ovf, unf);
        return t;
    endfunction

    task automatic chk(input string name, input int step, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic apply(input int step, input logic r, input logic pu, input logic po,
                         input logic [DW-1:0] wd, input exp_t e);
        exp_t g;
        @(negedge clk);
        reset_n = r;
        push    = pu;
        pop     = po;
        w_data  = wd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", step);
        end else begin
            g = sb.pop_front();
            chk("count", step, DW'(count), DW'(g.cnt));
            chk("top_data", step, top_data, g.top);
            chk("full", step, DW'(full), DW'(g.full));
            chk("empty", step, DW'(empty), DW'(g.empty));
            chk("almost_full", step, DW'(almost_full), DW'(g.af));
            chk("overflow", step, DW'(overflow), DW'(g.ovf));
            chk("underflow", step, DW'(underflow), DW'(g.unf));
        end
    endtask

    vec_t tbl [27];

    initial begin
        logic          r, pu, po, ovf, unf;
        logic [DW-1:0] wd;

        reset_n = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        w_data  = '0;

        tbl[0]  = v(0, 1, 0, 8'h99, 0, 8'h00, 0, 0);
        tbl[1]  = v(1, 1, 0, 8'h11, 1, 8'h11, 0, 0);
        tbl[2]  = v(1, 1, 0, 8'h22, 2, 8'h22, 0, 0);
        tbl[3]  = v(1, 1, 0, 8'h33, 3, 8'h33, 0, 0);
        tbl[4]  = v(1, 1, 0, 8'h44, 4, 8'h44, 0, 0);
        tbl[5]  = v(1, 1, 0, 8'h55, 4, 8'h44, 1, 0);
        tbl[6]  = v(1, 0, 0, 8'h00, 4, 8'h44, 0, 0);
        tbl[7]  = v(1, 0, 1, 8'h00, 3, 8'h33, 0, 0);
        tbl[8]  = v(1, 0, 1, 8'h00, 2, 8'h22, 0, 0);
        tbl[9]  = v(1, 0, 1, 8'h00, 1, 8'h11, 0, 0);
        tbl[10] = v(1, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        tbl[11] = v(1, 0, 1, 8'h00, 0, 8'h00, 0, 1);
        tbl[12] = v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        tbl[13] = v(1, 1, 0, 8'hA0, 1, 8'hA0, 0, 0);
        tbl[14] = v(1, 1, 1, 8'hB1, 1, 8'hB1, 0, 0);
        tbl[15] = v(1, 0, 1, 8'h00, 0, 8'h00, 0, 0);
        tbl[16] = v(1, 1, 1, 8'hC2, 1, 8'hC2, 0, 0);
        tbl[17] = v(1, 1, 0, 8'h01, 2, 8'h01, 0, 0);
        tbl[18] = v(1, 1, 0, 8'h02, 3, 8'h02, 0, 0);
        tbl[19] = v(0, 1, 0, 8'h77, 0, 8'h00, 0, 0);
        tbl[20] = v(1, 1, 0, 8'h03, 1, 8'h03, 0, 0);
        tbl[21] = v(1, 1, 0, 8'h04, 2, 8'h04, 0, 0);
        tbl[22] = v(1, 1, 0, 8'h05, 3, 8'h05, 0, 0);
        tbl[23] = v(1, 1, 0, 8'h06, 4, 8'h06, 0, 0);
        tbl[24] = v(1, 1, 1, 8'h07, 4, 8'h07, 0, 0);
        tbl[25] = v(1, 0, 1, 8'h00, 3, 8'h05, 0, 0);
        tbl[26] = v(1, 0, 1, 8'h00, 2, 8'h04, 0, 0);

        for (int i = 0; i < 27; i++) begin
            apply(i, tbl[i].rst_n, tbl[i].push, tbl[i].pop, tbl[i].wd, tbl[i].e);
        end

        // Back-to-back overflow then pop-to-empty back-to-back underflow.
        apply(100, 1, 1, 0, 8'hE0, mk(3, 8'hE0, 0, 0));
        apply(101, 1, 1, 0, 8'hE1, mk(4, 8'hE1, 0, 0));
        apply(102, 1, 1, 0, 8'hE2, mk(4, 8'hE1, 1, 0));
        apply(103, 1, 1, 0, 8'hE3, mk(4, 8'hE1, 1, 0));
        apply(104, 1, 0, 1, 8'h00, mk(3, 8'hE0, 0, 0));
        apply(105, 1, 0, 1, 8'h00, mk(2, 8'h04, 0, 0));
        apply(106, 1, 0, 1, 8'h00, mk(1, 8'h03, 0, 0));
        apply(107, 1, 0, 1, 8'h00, mk(0, 8'h00, 0, 0));
        apply(108, 1, 0, 1, 8'h00, mk(0, 8'h00, 0, 1));
        apply(109, 1, 0, 1, 8'h00, mk(0, 8'h00, 0, 1));
        apply(110, 1, 0, 0, 8'h00, mk(0, 8'h00, 0, 0));

        // Random traffic against a reference model.
        mcnt = 0;
        for (int i = 0; i < 120; i++) begin
            r   = ($urandom_range(0, 24) != 0);
            pu  = ($urandom_range(0, 2) != 0);
            po  = ($urandom_range(0, 2) == 0);
            wd  = DW'($urandom);
            ovf = 1'b0;
            unf = 1'b0;
            if (!r) begin
                mcnt = 0;
            end else if (pu && !po) begin
                if (mcnt == 4) ovf = 1'b1;
                else begin
                    mdl[mcnt] = wd;
                    mcnt++;
                end
            end else if (po && !pu) begin
                if (mcnt == 0) unf = 1'b1;
                else mcnt--;
            end else if (pu && po) begin
                if (mcnt == 0) begin
                    mdl[0] = wd;
                    mcnt = 1;
                end else begin
                    mdl[mcnt-1] = wd;
                end
            end
            apply(200 + i, r, pu, po, wd, mk(mcnt, (mcnt == 0) ? 8'h00 : mdl[mcnt-1], ovf, unf));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
